// File: rtl/nibble_add_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit ripple slice,
// walking the operands one nibble per clock from LSB to MSB.
module nibble_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic [4:0]       c;

    // Shared 4-bit slice; c[3] is kept so the MSB carry-in is visible for overflow.
    always_comb begin
        nib_a     = a_reg[{idx, 2'b00} +: 4];
        nib_b     = b_reg[{idx, 2'b00} +: 4];
        nib_s     = '0;
        c         = '0;
        c[0]      = carry;
        for (int i = 0; i < 4; i++) begin
            nib_s[i]  = nib_a[i] ^ nib_b[i] ^ c[i];
            c[i + 1]  = (nib_a[i] & nib_b[i]) | (c[i] & (nib_a[i] ^ nib_b[i]));
        end
        work_next = work;
        work_next[{idx, 2'b00} +: 4] = nib_s;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            work     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub | cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= c[4];
                    if (idx == LAST) begin
                        idx      <= '0;
                        sum      <= work_next;
                        cout     <= c[4];
                        overflow <= c[3] ^ c[4];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed self-checking bench for nibble_add_sequencer at WIDTH=16.
module tb_nibble_add_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    nibble_add_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum),
        .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Captures one operation; operands are scrambled right after capture.
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vsub, input logic vcin);
        a = va; b = vb; sub = vsub; cin = vcin; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~va; b = vb ^ 16'h5A5A; sub = ~vsub; cin = ~vcin;
    endtask

    task automatic runOp(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vsub, input logic vcin,
                         input logic [15:0] esum, input logic ecout, input logic eovf);
        int cycles;
        int busyCnt;
        applyStimulus(va, vb, vsub, vcin);
        cycles = 0;
        busyCnt = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (busy === 1'b1) busyCnt++;
            tick();
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, 4);
        checkOutput({tag, "_busycycles"}, busyCnt, 4);
        checkOutput({tag, "_busy_at_done"}, busy, 0);
        checkOutput({tag, "_sum"}, sum, esum);
        checkOutput({tag, "_cout"}, cout, ecout);
        checkOutput({tag, "_ovf"}, overflow, eovf);
        tick();
        checkOutput({tag, "_done_pulse"}, done, 0);
        checkOutput({tag, "_sum_hold"}, sum, esum);
    endtask

    initial begin
        int doneCnt;
        int t;
        int t1;
        int t2;

        $display("[TB] start");
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_cout", cout, 0);
        checkOutput("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_busy", busy, 0);

        runOp("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        runOp("addFFFF", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp("addcin",  16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        runOp("addovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        runOp("subovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        runOp("subbrw",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        runOp("addmix",  16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // start pulsed during RUN and during DONE must be ignored
        applyStimulus(16'h0010, 16'h0020, 1'b0, 1'b0);
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            start = (i == 1 || i == 3) ? 1'b1 : 1'b0;
            if (done === 1'b1) start = 1'b1;
            tick();
            if (done === 1'b1) doneCnt++;
        end
        start = 1'b0;
        checkOutput("ignore_done_count", doneCnt, 1);
        checkOutput("ignore_sum", sum, 16'h0030);
        checkOutput("ignore_busy", busy, 0);

        // start held high: completions spaced N+2 cycles
        a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        t = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && t < 40) begin
            tick();
            t++;
            if (done === 1'b1) begin
                if (t1 < 0) t1 = t;
                else t2 = t;
            end
        end
        start = 1'b0;
        checkOutput("held_spacing", t2 - t1, 6);
        checkOutput("held_sum", sum, 16'h0002);
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();

        // reset in the 2nd RUN cycle aborts the op
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        checkOutput("abort_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_sum", sum, 0);
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) doneCnt++;
        end
        checkOutput("abort_no_done", doneCnt, 0);

        // rst and start together: nothing captured
        a = 16'h0F0F; b = 16'h0101; rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        checkOutput("rststart_busy", busy, 0);
        tick();
        checkOutput("rststart_busy2", busy, 0);
        checkOutput("rststart_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_add_sequencer.md
Name: nibble_add_sequencer

Overview:
Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit full-adder slice. The sequencer latches both operands, feeds the slice one nibble per clock from LSB to MSB, and keeps the inter-nibble carry in a register. The assembled result is presented with a start/busy/done handshake. It sits between switch/operand registers and the LED/display logic on the Basys3 top level.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; N = WIDTH/4 nibble steps.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = add, 1 = subtract (a - b); sampled with start
cin  input  1  carry-in for add; ignored when sub=1
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse
sum  output  WIDTH  result, held between completions
cout  output  1  carry out of the MSB (for subtract: 1 = no borrow)
overflow  output  1  two's-complement overflow of the last operation

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset:
  - state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal operand registers, carry register and nibble index are cleared.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If start=1 at a rising edge, latch a, b', carry, then go to RUN with idx=0.
  - b' = sub ? ~b : b.
  - carry = sub ? 1 : cin.
  - If start=0, stay in IDLE.
- RUN, at each edge:
  - Slice inputs: A = a_reg[4*idx+3:4*idx], B = b'_reg[same bits], Cin = carry.
  - Slice equations per bit: s = A^B^Cin; c = A&B | Cin&(A^B). Carries ripple inside the nibble.
  - Write the slice sum nibble into the working result at idx, update carry from the nibble carry-out, then idx++.
  - On the edge where idx = N-1, go to DONE.
  - Also on that edge, transfer the working result to sum. Set cout = final carry. Set overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - start is ignored in DONE; it is ignored in RUN as well.
- Latency:
  - Capture edge E0; compute edges E1..EN.
  - done is high between EN and EN+1; for WIDTH=16, done is visible 4 edges after capture.
  - Back-to-back operation costs N+2 cycles per op.
- busy = 1 exactly while state = RUN; it is never high together with done.
- Operand isolation: changes on a, b, sub and cin after the capture edge have no effect on the running operation.
- Stability: sum, cout and overflow change only on the edge entering DONE (or on reset) and hold their values through IDLE and the following RUN.
- Wrap-around: the result is modulo 2^WIDTH; cout reports the bit lost.
- Reset mid-operation: rst during RUN or DONE aborts the operation. No done pulse is produced, and all outputs return to reset values on that edge.
- Simultaneous rst and start: rst wins and nothing is captured.
- Start held high continuously: a new operation is captured on every return to IDLE, one operation per N+2 cycles.

Test Plan:
1. Reset, then add with a=16'h1234, b=16'h4321, cin=0 → busy high for 4 cycles; done pulses 4 edges after capture; sum=16'h5555, cout=0, overflow=0.
2. Add with a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, overflow=0 (carry ripples across all 4 nibble steps). Repeat with cin=1 and b=0 → same result.
3. Add with a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, overflow=1. Subtract with sub=1, a=16'h8000, b=16'h0001 → sum=16'h7FFF, cout=1, overflow=1.
4. Subtract with sub=1, a=16'h0003, b=16'h0005 → sum=16'hFFFE, cout=0 (borrow), overflow=0. Change a and b during RUN → result unchanged.
5. Pulse start during RUN and during DONE → ignored: no second capture, single done pulse. Hold start high → two completed ops exactly 6 cycles apart.
6. Assert rst at the 2nd RUN cycle → next cycle busy=0, done=0, sum=0; no done pulse follows. Assert rst and start together → stays in IDLE.
